// File: rtl/conv_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, config host,
// weight loader and conv unit.
interface conv_layer_sequencer_if #(
  parameter int LAYER_IDX_W = 3,
  parameter int TILE_CNT_W  = 16,
  parameter int WBEATS_W    = 12
);
  logic                   cfg_we;
  logic [LAYER_IDX_W-1:0] cfg_layer;
  logic [TILE_CNT_W-1:0]  cfg_tiles;
  logic [WBEATS_W-1:0]    cfg_wbeats;
  logic [LAYER_IDX_W:0]   layer_count;
  logic                   start;
  logic                   abort;
  logic                   wload_req;
  logic [LAYER_IDX_W-1:0] wload_layer;
  logic [WBEATS_W-1:0]    wload_beats;
  logic                   wload_bank;
  logic                   wload_done;
  logic                   tile_start;
  logic                   tile_done;
  logic [LAYER_IDX_W-1:0] current_layer;
  logic                   compute_bank;
  logic                   state_rst;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output cfg_we, cfg_layer, cfg_tiles, cfg_wbeats,
    output layer_count, start, abort,
    output wload_done, tile_done,
    input  wload_req, wload_layer, wload_beats, wload_bank,
    input  tile_start, current_layer, compute_bank,
    input  state_rst, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_layer, cfg_tiles, cfg_wbeats,
    input  layer_count, start, abort,
    input  wload_done, tile_done,
    output wload_req, wload_layer, wload_beats, wload_bank,
    output tile_start, current_layer, compute_bank,
    output state_rst, busy, done, err
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Multi-layer CNN sequencer: weight load, tile compute, layer reset.
// Define LAYER_SEQ_PREFETCH_EN to overlap next-layer loads with compute.
module conv_layer_sequencer #(
  parameter int NUM_LAYERS  = 8,
  parameter int LAYER_IDX_W = 3,
  parameter int TILE_CNT_W  = 16,
  parameter int WBEATS_W    = 12
) (
  input logic clk,
  input logic rst,
  conv_layer_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, COMPUTE, WAIT_TILE, NEXT
  } state_t;

  localparam int LW = LAYER_IDX_W + 1;
  localparam logic [LW-1:0] MAX_LAYERS = LW'(NUM_LAYERS);

  logic [TILE_CNT_W-1:0] tiles_tab [NUM_LAYERS];
  logic [WBEATS_W-1:0]   beats_tab [NUM_LAYERS];

  state_t                 state;
  logic [LAYER_IDX_W-1:0] layer;
  logic [LW-1:0]          lcount;
  logic [TILE_CNT_W-1:0]  tile_cnt;
  logic                   req;
  logic [LAYER_IDX_W-1:0] ld_layer;
  logic [WBEATS_W-1:0]    ld_beats;
  logic                   tstart;
  logic                   srst;
  logic                   running;
  logic                   fin;
  logic                   bad;

  logic [LAYER_IDX_W-1:0] nxt_layer;
  logic [TILE_CNT_W-1:0]  tile_inc;
  logic                   last_layer;
  logic                   last_tile;
  logic                   start_ok;
  logic                   cfg_hit;

  assign nxt_layer  = layer + 1'b1;
  assign tile_inc   = tile_cnt + 1'b1;
  assign last_layer = ({1'b0, layer} + LW'(1)) == lcount;
  assign last_tile  = tile_inc == tiles_tab[layer];
  assign start_ok   = (bus.layer_count != '0)
                   && (bus.layer_count <= MAX_LAYERS);
  assign cfg_hit    = bus.cfg_we && !running
                   && ({1'b0, bus.cfg_layer} < MAX_LAYERS);

`ifdef LAYER_SEQ_PREFETCH_EN
  logic ld_bank;
  logic cmp_bank;
  logic pf_issued;
  logic pf_ready;
  logic pf_hit;

  assign pf_hit = pf_issued && !pf_ready && bus.wload_done;
`endif

  // Layer config table; zero tiles stored as one, writes only when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        tiles_tab[i] <= TILE_CNT_W'(1);
        beats_tab[i] <= '0;
      end
    end else if (cfg_hit) begin
      tiles_tab[bus.cfg_layer] <= (bus.cfg_tiles == '0)
                                ? TILE_CNT_W'(1) : bus.cfg_tiles;
      beats_tab[bus.cfg_layer] <= bus.cfg_wbeats;
    end
  end

  // Run FSM with registered outputs; abort overrides every event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      layer    <= '0;
      lcount   <= '0;
      tile_cnt <= '0;
      req      <= 1'b0;
      ld_layer <= '0;
      ld_beats <= '0;
      tstart   <= 1'b0;
      srst     <= 1'b0;
      running  <= 1'b0;
      fin      <= 1'b0;
      bad      <= 1'b0;
`ifdef LAYER_SEQ_PREFETCH_EN
      ld_bank   <= 1'b0;
      cmp_bank  <= 1'b0;
      pf_issued <= 1'b0;
      pf_ready  <= 1'b0;
`endif
    end else begin
      tstart <= 1'b0;
      srst   <= 1'b0;
      fin    <= 1'b0;
      bad    <= 1'b0;
      if (bus.abort) begin
        state    <= IDLE;
        layer    <= '0;
        tile_cnt <= '0;
        req      <= 1'b0;
        ld_layer <= '0;
        ld_beats <= '0;
        running  <= 1'b0;
`ifdef LAYER_SEQ_PREFETCH_EN
        ld_bank   <= 1'b0;
        cmp_bank  <= 1'b0;
        pf_issued <= 1'b0;
        pf_ready  <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              if (start_ok) begin
                state    <= LOAD;
                lcount   <= bus.layer_count;
                layer    <= '0;
                tile_cnt <= '0;
                req      <= 1'b1;
                ld_layer <= '0;
                ld_beats <= beats_tab[0];
                running  <= 1'b1;
`ifdef LAYER_SEQ_PREFETCH_EN
                ld_bank   <= 1'b0;
                cmp_bank  <= 1'b0;
                pf_issued <= 1'b0;
                pf_ready  <= 1'b0;
`endif
              end else begin
                bad <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (bus.wload_done) begin
              req    <= 1'b0;
              tstart <= 1'b1;
              state  <= COMPUTE;
            end
          end
          COMPUTE: begin
            state <= WAIT_TILE;
          end
          WAIT_TILE: begin
            if (bus.tile_done) begin
              if (last_tile) begin
                tile_cnt <= '0;
                srst     <= 1'b1;
                fin      <= last_layer;
                state    <= NEXT;
              end else begin
                tile_cnt <= tile_inc;
                tstart   <= 1'b1;
                state    <= COMPUTE;
              end
            end
          end
          NEXT: begin
            if (last_layer) begin
              state   <= IDLE;
              running <= 1'b0;
            end else begin
              layer <= nxt_layer;
`ifdef LAYER_SEQ_PREFETCH_EN
              cmp_bank  <= ~cmp_bank;
              pf_issued <= 1'b0;
              pf_ready  <= 1'b0;
              if (pf_ready || pf_hit) begin
                req    <= 1'b0;
                tstart <= 1'b1;
                state  <= COMPUTE;
              end else begin
                state <= LOAD;
              end
`else
              req      <= 1'b1;
              ld_layer <= nxt_layer;
              ld_beats <= beats_tab[nxt_layer];
              state    <= LOAD;
`endif
            end
          end
          default: state <= IDLE;
        endcase
`ifdef LAYER_SEQ_PREFETCH_EN
        if (state == COMPUTE || state == WAIT_TILE) begin
          if (!pf_issued && !last_layer) begin
            req       <= 1'b1;
            ld_layer  <= nxt_layer;
            ld_beats  <= beats_tab[nxt_layer];
            ld_bank   <= ~cmp_bank;
            pf_issued <= 1'b1;
          end else if (pf_hit) begin
            req      <= 1'b0;
            pf_ready <= 1'b1;
          end
        end
`endif
      end
    end
  end

  assign bus.wload_req     = req;
  assign bus.wload_layer   = ld_layer;
  assign bus.wload_beats   = ld_beats;
  assign bus.tile_start    = tstart;
  assign bus.current_layer = layer;
  assign bus.state_rst     = srst;
  assign bus.busy          = running;
  assign bus.done          = fin;
  assign bus.err           = bad;
`ifdef LAYER_SEQ_PREFETCH_EN
  assign bus.wload_bank    = ld_bank;
  assign bus.compute_bank  = cmp_bank;
`else
  assign bus.wload_bank    = 1'b0;
  assign bus.compute_bank  = 1'b0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: vector table plus
// hand-written abort, reset, busy-write and prefetch sequences.
module tb_conv_layer_sequencer;
  localparam int NL  = 8;
  localparam int LIW = 3;
  localparam int TCW = 16;
  localparam int WBW = 12;

  typedef struct {
    int lc;
    int t[3];
    int w[3];
    int ts;
    int sr;
    int dn;
    int er;
    int rq;
    int b0;
    int b1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic auto_en;
  logic a_wdone, a_tdone, m_wdone, m_tdone;
  logic clr;
  int   wlat, tlat;

  int n_cmp = 0;
  int n_bad = 0;

  int n_ts, n_sr, n_done, n_err, n_req;
  int done_sr, busy_after, gap_first, sr_cyc, cyc;
  bit done_prev, req_prev, gap_pending;
  int beats_log[8];
  int bank_log[8];
  int wbank_log[8];
  int wlayer_log[8];

  vec_t vecs[6];

  conv_layer_sequencer_if #(
    .LAYER_IDX_W(LIW), .TILE_CNT_W(TCW), .WBEATS_W(WBW)
  ) bus ();

  conv_layer_sequencer #(
    .NUM_LAYERS(NL), .LAYER_IDX_W(LIW),
    .TILE_CNT_W(TCW), .WBEATS_W(WBW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.wload_done = auto_en ? a_wdone : m_wdone;
  assign bus.tile_done  = auto_en ? a_tdone : m_tdone;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // auto responder: wload_done wlat cycles after req, tile_done tlat after start
  initial begin
    int wcnt, tcnt;
    wcnt = 0;
    tcnt = 0;
    a_wdone = 1'b0;
    a_tdone = 1'b0;
    forever begin
      @(negedge clk);
      a_wdone = 1'b0;
      a_tdone = 1'b0;
      if (auto_en) begin
        if (bus.wload_req) begin
          wcnt++;
          if (wcnt == wlat) begin
            a_wdone = 1'b1;
            wcnt = 0;
          end
        end else begin
          wcnt = 0;
        end
        if (bus.tile_start) tcnt = 1;
        else if (tcnt != 0) tcnt++;
        if (tcnt == tlat) begin
          a_tdone = 1'b1;
          tcnt = 0;
        end
      end else begin
        wcnt = 0;
        tcnt = 0;
      end
    end
  end

  // event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (clr) begin
        n_ts = 0; n_sr = 0; n_done = 0; n_err = 0; n_req = 0;
        done_sr = -1; busy_after = -1; gap_first = -1;
        sr_cyc = 0; done_prev = 0; gap_pending = 0;
        for (int i = 0; i < 8; i++) begin
          beats_log[i] = -1;
          bank_log[i] = -1;
          wbank_log[i] = -1;
          wlayer_log[i] = -1;
        end
      end
      cyc++;
      if (bus.tile_start) begin
        n_ts++;
        if (gap_pending) begin
          gap_first = cyc - sr_cyc;
          gap_pending = 0;
        end
      end
      if (bus.state_rst) begin
        if (n_sr < 8) bank_log[n_sr] = int'(bus.compute_bank);
        if (n_sr == 0) begin
          sr_cyc = cyc;
          gap_pending = 1;
        end
        n_sr++;
      end
      if (done_prev) busy_after = int'(bus.busy);
      done_prev = bus.done;
      if (bus.done) begin
        n_done++;
        done_sr = int'(bus.state_rst);
      end
      if (bus.err) n_err++;
      if (bus.wload_req && !req_prev) begin
        if (n_req < 8) begin
          beats_log[n_req]  = int'(bus.wload_beats);
          wbank_log[n_req]  = int'(bus.wload_bank);
          wlayer_log[n_req] = int'(bus.current_layer);
        end
        n_req++;
      end
      req_prev = bus.wload_req;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic cfg_wr(input int idx, input int t, input int w);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_layer  = LIW'(idx);
    bus.cfg_tiles  = TCW'(t);
    bus.cfg_wbeats = WBW'(w);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int lc);
    @(negedge clk);
    bus.layer_count = (LIW + 1)'(lc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end();
    bit seen;
    seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = (n_done > 0) || (n_err > 0);
    end
    chk("run_end", int'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int lc);
    clear_mon();
    pulse_start(lc);
    wait_end();
  endtask

  initial begin
    cyc = 0;
    clr = 1'b1;
    rst = 1'b1;
    auto_en = 1'b0;
    m_wdone = 1'b0;
    m_tdone = 1'b0;
    wlat = 5;
    tlat = 4;
    bus.cfg_we = 1'b0;
    bus.cfg_layer = '0;
    bus.cfg_tiles = '0;
    bus.cfg_wbeats = '0;
    bus.layer_count = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    vecs[0] = '{2, '{3, 2, 1}, '{10, 20, 0}, 5, 2, 1, 0, 2, 10, 20};
    vecs[1] = '{0, '{1, 1, 1}, '{4, 4, 4}, 0, 0, 0, 1, 0, -1, -1};
    vecs[2] = '{9, '{1, 1, 1}, '{4, 4, 4}, 0, 0, 0, 1, 0, -1, -1};
    vecs[3] = '{1, '{0, 1, 1}, '{5, 6, 6}, 1, 1, 1, 0, 1, 5, -1};
    vecs[4] = '{3, '{1, 2, 3}, '{7, 8, 9}, 6, 3, 1, 0, 3, 7, 8};
    vecs[5] = '{8, '{1, 1, 1}, '{1, 2, 3}, 8, 8, 1, 0, 8, 1, 2};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wreq", int'(bus.wload_req), 0);
    chk("rst_tstart", int'(bus.tile_start), 0);
    chk("rst_srst", int'(bus.state_rst), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_layer", int'(bus.current_layer), 0);
    chk("rst_cbank", int'(bus.compute_bank), 0);
    rst = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    auto_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++)
        cfg_wr(j, vecs[i].t[j], vecs[i].w[j]);
      run(vecs[i].lc);
      chk($sformatf("v%0d_tiles", i), n_ts, vecs[i].ts);
      chk($sformatf("v%0d_srst", i), n_sr, vecs[i].sr);
      chk($sformatf("v%0d_done", i), n_done, vecs[i].dn);
      chk($sformatf("v%0d_err", i), n_err, vecs[i].er);
      chk($sformatf("v%0d_nreq", i), n_req, vecs[i].rq);
      chk($sformatf("v%0d_beats0", i), beats_log[0], vecs[i].b0);
      chk($sformatf("v%0d_beats1", i), beats_log[1], vecs[i].b1);
      chk($sformatf("v%0d_busy_end", i), int'(bus.busy), 0);
      if (vecs[i].dn != 0) begin
        chk($sformatf("v%0d_done_w_srst", i), done_sr, 1);
        chk($sformatf("v%0d_busy_after", i), busy_after, 0);
      end
    end

    // abort on the same cycle as the final tile_done
    auto_en = 1'b0;
    cfg_wr(0, 2, 9);
    clear_mon();
    pulse_start(1);
    chk("ab_busy_t1", int'(bus.busy), 1);
    chk("ab_wreq_t1", int'(bus.wload_req), 1);
    chk("ab_beats", int'(bus.wload_beats), 9);
    m_wdone = 1'b1;
    @(negedge clk);
    m_wdone = 1'b0;
    chk("ab_wreq_u1", int'(bus.wload_req), 0);
    chk("ab_tstart_u1", int'(bus.tile_start), 1);
    @(negedge clk);
    m_tdone = 1'b1;
    @(negedge clk);
    m_tdone = 1'b0;
    chk("ab_tstart_v1", int'(bus.tile_start), 1);
    @(negedge clk);
    m_tdone = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    m_tdone = 1'b0;
    bus.abort = 1'b0;
    chk("ab_srst", int'(bus.state_rst), 0);
    chk("ab_done", int'(bus.done), 0);
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_wreq", int'(bus.wload_req), 0);
    repeat (2) @(negedge clk);
    chk("ab_nsrst", n_sr, 0);
    chk("ab_ndone", n_done, 0);
    auto_en = 1'b1;
    run(1);
    chk("ab_rerun_tiles", n_ts, 2);
    chk("ab_rerun_done", n_done, 1);

    // config write while busy is dropped
    cfg_wr(0, 1, 33);
    clear_mon();
    pulse_start(1);
    cfg_wr(0, 1, 44);
    wait_end();
    run(1);
    chk("busy_wr_beats", beats_log[0], 33);

    // reset asserted mid WAIT_TILE
    auto_en = 1'b0;
    cfg_wr(0, 5, 7);
    clear_mon();
    pulse_start(1);
    m_wdone = 1'b1;
    @(negedge clk);
    m_wdone = 1'b0;
    @(negedge clk);
    chk("mr_busy_pre", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_wreq", int'(bus.wload_req), 0);
    chk("mr_tstart", int'(bus.tile_start), 0);
    chk("mr_srst", int'(bus.state_rst), 0);
    chk("mr_done", int'(bus.done), 0);
    chk("mr_beats", int'(bus.wload_beats), 0);
    @(negedge clk);
    rst = 1'b0;
    auto_en = 1'b1;
    run(1);
    chk("mr_tab_beats", beats_log[0], 0);
    chk("mr_tab_tiles", n_ts, 1);

`ifdef LAYER_SEQ_PREFETCH_EN
    cfg_wr(0, 2, 1);
    cfg_wr(1, 2, 2);
    cfg_wr(2, 2, 3);
    run(3);
    chk("pf_tiles", n_ts, 6);
    chk("pf_nreq", n_req, 3);
    chk("pf_wbank1", wbank_log[1], 1);
    chk("pf_wlayer1", wlayer_log[1], 0);
    chk("pf_beats2", beats_log[2], 3);
    chk("pf_gap", gap_first, 1);
    chk("pf_cbank0", bank_log[0], 0);
    chk("pf_cbank1", bank_log[1], 1);
    chk("pf_cbank2", bank_log[2], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Parametrised multi-layer sequencer for the CNN datapath. It supersedes the fixed 3-bit layer state machine. It walks a programmable table of up to NUM_LAYERS layers. For each layer it requests the layer's weights from the weight memory loader, issues one compute pulse per output tile to the conv unit, and pulses `state_rst` at every layer boundary. Optionally it prefetches the next layer's weights into the alternate bank while the current layer computes.

## Interface
Parameters:
- NUM_LAYERS, 8, depth of layer config table (≥2)
- LAYER_IDX_W, 3, layer index width; 2^LAYER_IDX_W ≥ NUM_LAYERS
- TILE_CNT_W, 16, tiles-per-layer field width
- WBEATS_W, 12, weight-load beat-count field width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write config entry; honoured only when busy=0
- cfg_layer  in  LAYER_IDX_W  entry index; ≥NUM_LAYERS ignored
- cfg_tiles  in  TILE_CNT_W  tiles for entry; 0 treated as 1
- cfg_wbeats  in  WBEATS_W  DDR beats of weights for entry
- layer_count  in  LAYER_IDX_W+1  layers to run, sampled on start
- start  in  1  run request, honoured in IDLE only
- abort  in  1  synchronous abort, any state
- wload_req  out  1  weight-load request, level, held until wload_done
- wload_layer  out  LAYER_IDX_W  layer being loaded, stable while wload_req=1
- wload_beats  out  WBEATS_W  beats for that layer, stable while wload_req=1
- wload_bank  out  1  destination weight bank
- wload_done  in  1  one-cycle pulse, load complete
- tile_start  out  1  one-cycle pulse, compute one tile
- tile_done  in  1  one-cycle pulse, tile finished
- current_layer  out  LAYER_IDX_W  layer in compute
- compute_bank  out  1  bank the conv unit reads
- state_rst  out  1  one-cycle pulse at each layer end
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, run complete
- err  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT_TILE, NEXT.
- IDLE with start=1:
  - layer_count=0 or layer_count>NUM_LAYERS: err=1 next cycle, remain IDLE.
  - Otherwise: latch layer_count, set layer=0, set both banks to 0, go LOAD.
- LOAD: wload_req=1 with wload_layer=layer and wload_beats=table[layer].
  - On wload_done: drop wload_req, go COMPUTE.
- COMPUTE: tile_start=1 for one cycle, go WAIT_TILE.
- WAIT_TILE: on tile_done, tile_cnt++.
  - If tile_cnt reaches table[layer].tiles: go NEXT.
  - Otherwise: go COMPUTE.
- NEXT: state_rst=1 and tile_cnt cleared.
  - If layer=layer_count-1: done=1, go IDLE.
  - Otherwise: layer++ and go LOAD (prefetch behaviour in Configuration).
- abort has priority over every other event, including tile_done, wload_done and start in the same cycle.
  - Next cycle: IDLE, wload_req=0, no state_rst and no done.
  - The config table is kept.
- tile_done and wload_done are ignored in states that do not wait for them.
- Config writes while busy=1 are dropped.
- Table reset value: tiles=1, wbeats=0.

## Timing
- Reset values: all outputs 0, state IDLE, tile_cnt 0, banks 0.
- start at cycle t (accepted): busy=1 and wload_req=1 at t+1.
- wload_done at u: wload_req=0 and tile_start=1 at u+1.
- tile_done at v, more tiles remaining: tile_start at v+1.
- tile_done at v, last tile of layer: state_rst at v+1.
  - Last layer: done also at v+1, busy=0 at v+2.
  - Otherwise (no prefetch): wload_req at v+2.
- Minimum tile period: 2 cycles.
- abort at cycle a: all outputs idle at a+1.

## Configuration
- Macro: LAYER_SEQ_PREFETCH_EN.
- Defined:
  - While in COMPUTE/WAIT_TILE with layer+1<layer_count and no prefetch issued for this layer:
    - Assert wload_req for layer+1 with wload_bank=~compute_bank.
    - wload_done marks the prefetch ready.
  - In NEXT with prefetch ready: compute_bank toggles, skip LOAD, tile_start at v+2.
  - In NEXT with prefetch still in flight: go LOAD and keep wload_req held (no re-issue). The pending wload_done completes it.
  - Exactly one prefetch outstanding at a time.
- Undefined:
  - wload_bank and compute_bank are tied 0.
  - No load is overlapped with compute.

## Test plan
- Reset: assert rst mid-WAIT_TILE -> all outputs 0 immediately, IDLE after release, config table reset to tiles=1/wbeats=0.
- Two layers, tiles {3,2}, wbeats {10,20}, wload_done 5 cycles after each req, tile_done 4 cycles after each tile_start:
  - Required: 5 tile_start pulses.
  - Required: wload_beats 10 then 20.
  - Required: state_rst twice.
  - Required: done coincident with the second state_rst.
  - Required: busy=0 one cycle later.
- start with layer_count=0 and layer_count=NUM_LAYERS+1 -> err pulse each time, busy stays 0, no wload_req.
- abort on the same cycle as the final tile_done -> no state_rst, no done, IDLE next cycle. A following start runs normally.
- cfg_tiles=0 for a layer -> exactly 1 tile_start for that layer. cfg_we while busy -> table unchanged (read back via wload_beats on the next run).
- With LAYER_SEQ_PREFETCH_EN, 3 layers, load finishing before compute:
  - Required: second wload_req appears during layer-0 WAIT_TILE with wload_bank=1.
  - Required: tile_start 2 cycles after the layer-0 last tile_done.
  - Required: compute_bank sequence 0,1,0.
